conv_pe_sequencer: RTL and testbench
====================================

Name: conv_pe_sequencer

Overview:
Cycle-accurate controller for the 16-PE convolution sub-top. It generates the cal_start, PE_reset and PE_finish strobe sequence that computes one OFM pixel per period, and counts pixels until the layer is done. It replaces hand-timed bench stimulus, supports per-layer configuration, and applies output backpressure before each PE_finish.

Parameters:
NUM_PE, 16, width of the PE_reset/PE_finish vectors (all bits driven identically)
CNT_W, 16, width of the configuration and pixel counters
START_DELAY, 3, cycles that cal_start is high before the first PE_reset (minimum 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a layer; honoured only in IDLE
abort  input  1  synchronous abort; returns the block to IDLE next cycle
cfg_acc_cycles  input  CNT_W  accumulate cycles between PE_reset and PE_finish (num_tiles*kernel_W - 2; 34 for 3x3x16)
cfg_num_pixels  input  CNT_W  OFM pixels per layer (3136 for 56x56)
ofm_ready  input  1  downstream can accept a result; gates PE_finish
cal_start  output  1  compute-enable to the datapath
PE_reset  output  NUM_PE  one-cycle accumulator clear, all bits equal
PE_finish  output  NUM_PE  one-cycle result strobe, all bits equal
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last pixel
pixel_idx  output  CNT_W  index of the pixel in progress, 0-based

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; all counters 0.
- States: IDLE, WARMUP, CLEAR, ACCUM, FINISH, DONE. State and outputs are registered; outputs reflect the current state.
- IDLE: start=1 latches cfg_acc_cycles and cfg_num_pixels. Inputs are ignored outside IDLE; mid-layer cfg changes have no effect.
  - latched num_pixels=0 -> DONE (no cal_start, no strobes)
  - otherwise -> WARMUP
- WARMUP: cal_start=1 for exactly START_DELAY cycles, then -> CLEAR.
- CLEAR: PE_reset=all-ones for 1 cycle.
  - latched acc=0 -> FINISH
  - otherwise -> ACCUM
- ACCUM: exactly acc cycles, with both strobes 0, then -> FINISH.
- FINISH: PE_finish is driven only while ofm_ready=1.
  - ofm_ready=0: hold FINISH with PE_finish=0 (stall; no timeout).
  - ofm_ready=1: PE_finish=all-ones for that cycle. If pixel_idx = num-1 -> DONE; else pixel_idx+1 and -> CLEAR.
- DONE: done=1 for 1 cycle, cal_start=0, pixel_idx=0 -> IDLE.
- cal_start=1 in WARMUP, CLEAR, ACCUM and FINISH; 0 in IDLE and DONE.
- Unstalled pixel period: acc+2 cycles (CLEAR + ACCUM + FINISH); 36 for acc=34.
- PE_reset and PE_finish are never high in the same cycle. Consecutive pixels are back-to-back: PE_finish in cycle t, PE_reset in t+1.
- Layer latency, unstalled: from the cycle start is sampled to the done pulse = START_DELAY + num*(acc+2) + 1 cycles.
- abort=1 has priority over every transition: next state IDLE, all outputs 0, counters cleared, no done pulse. Simultaneous start+abort in IDLE: abort wins, stays IDLE.
- start while busy: ignored (no restart, no queueing).
- reset asserted mid-layer: immediate return to reset values. After release, the block waits in IDLE for a new start.
- Counters wrap-free: the ACCUM counter compares against the latched acc; pixel_idx never exceeds num-1.

Test Plan:
- acc=34, num=4, ofm_ready=1, pulse start -> cal_start rises the next cycle; first PE_reset 3 cycles later; PE_finish pulses 36 cycles apart; 4 PE_finish total; done 1+3+144 cycles after start; busy falls with done.
- acc=0, num=3 -> PE_reset/PE_finish alternate every cycle (period 2); done after 3 PE_finish.
- acc=34, num=2, ofm_ready=0 for 10 cycles at the first FINISH -> PE_finish delayed exactly 10 cycles; cal_start stays 1; second pixel timing is unchanged relative to its PE_reset.
- abort asserted during ACCUM of pixel 5 (num=3136) -> next cycle all outputs 0, busy=0, no done; a later start runs a full layer from pixel_idx 0.
- num=0, start -> done pulse 1 cycle after start; cal_start, PE_reset and PE_finish never assert.
- reset driven low during pixel 2, and start pulsed while busy in a separate run -> outputs clear immediately on reset; the start while busy does not alter the strobe count (exactly num PE_finish pulses).

Source files
------------

// File: rtl/conv_pe_sequencer.sv
// Strobe sequencer for the 16-PE convolution sub-top: warms up the datapath,
// then runs one CLEAR/ACCUM/FINISH period per OFM pixel until the layer is done.
module conv_pe_sequencer #(
   parameter int NUM_PE      = 16,
   parameter int CNT_W       = 16,
   parameter int START_DELAY = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  cfg_acc_cycles,
   input  logic [CNT_W-1:0]  cfg_num_pixels,
   input  logic              ofm_ready,
   output logic              cal_start,
   output logic [NUM_PE-1:0] PE_reset,
   output logic [NUM_PE-1:0] PE_finish,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pixel_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARMUP,
      S_CLEAR,
      S_ACCUM,
      S_FINISH,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(START_DELAY - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pix_q, pix_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] num_q, num_d;

   // State, cycle counter, pixel counter and latched layer configuration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pix_q   <= '0;
         acc_q   <= '0;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pix_q   <= pix_d;
         acc_q   <= acc_d;
         num_q   <= num_d;
      end
   end

   // Next-state logic; abort overrides every transition and clears all counters.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pix_d   = pix_q;
      acc_d   = acc_q;
      num_d   = num_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = cfg_acc_cycles;
               num_d   = cfg_num_pixels;
               cnt_d   = '0;
               pix_d   = '0;
               state_d = (cfg_num_pixels == '0) ? S_DONE : S_WARMUP;
            end
         end
         S_WARMUP: begin
            if (cnt_q == WARM_LAST) begin
               cnt_d   = '0;
               state_d = S_CLEAR;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = (acc_q == '0) ? S_FINISH : S_ACCUM;
         end
         S_ACCUM: begin
            if (cnt_q == acc_q - ONE) begin
               cnt_d   = '0;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_FINISH: begin
            if (ofm_ready) begin
               if (pix_q == num_q - ONE) begin
                  pix_d   = '0;
                  state_d = S_DONE;
               end else begin
                  pix_d   = pix_q + ONE;
                  state_d = S_CLEAR;
               end
            end
         end
         S_DONE: begin
            pix_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         pix_d   = '0;
         acc_d   = '0;
         num_d   = '0;
      end
   end

   // Outputs decode the registered state; PE_finish is additionally gated by ofm_ready.
   always_comb begin
      cal_start = 1'b0;
      PE_reset  = '0;
      PE_finish = '0;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      pixel_idx = pix_q;
      case (state_q)
         S_WARMUP: cal_start = 1'b1;
         S_CLEAR: begin
            cal_start = 1'b1;
            PE_reset  = '1;
         end
         S_ACCUM:  cal_start = 1'b1;
         S_FINISH: begin
            cal_start = 1'b1;
            PE_finish = ofm_ready ? '1 : '0;
         end
         S_DONE:   done = 1'b1;
         default: begin
            cal_start = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Scoreboard bench for conv_pe_sequencer: stimulus pushes the hand-derived
// PE_reset/PE_finish/done cycle numbers, a negedge monitor pops and compares.
module tb_conv_pe_sequencer;

   localparam int NUM_PE = 16;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  cfg_acc_cycles;
   logic [CNT_W-1:0]  cfg_num_pixels;
   logic              ofm_ready;
   logic              cal_start;
   logic [NUM_PE-1:0] PE_reset;
   logic [NUM_PE-1:0] PE_finish;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  pixel_idx;

   conv_pe_sequencer #(.NUM_PE(NUM_PE), .CNT_W(CNT_W), .START_DELAY(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .cfg_acc_cycles (cfg_acc_cycles),
      .cfg_num_pixels (cfg_num_pixels),
      .ofm_ready      (ofm_ready),
      .cal_start      (cal_start),
      .PE_reset       (PE_reset),
      .PE_finish      (PE_finish),
      .busy           (busy),
      .done           (done),
      .pixel_idx      (pixel_idx)
   );

   typedef struct {
      int kind;
      int cyc;
      int pix;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   int  t0;

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle index used as the time base for every expected event.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // kind 0 = PE_reset, 1 = PE_finish, 2 = done
   task automatic popEvent(input int kind, input logic [NUM_PE-1:0] vec);
      ev_t e;
      if (kind < 2) checkOutput("strobe_all_bits", {16'd0, vec}, {16'd0, {NUM_PE{1'b1}}});
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL unexpected_event kind=%0d at cycle %0d required=none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         checkOutput("event_kind", kind, e.kind);
         checkOutput("event_cycle", cyc, e.cyc);
         checkOutput("event_pixel", {16'd0, pixel_idx}, e.pix);
      end
   endtask

   // Monitor: samples on the falling edge and matches strobes against the scoreboard.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (PE_reset != '0 && PE_finish != '0)
            checkOutput("strobe_overlap", 1, 0);
         if (PE_reset != '0) popEvent(0, PE_reset);
         if (PE_finish != '0) popEvent(1, PE_finish);
         if (done) popEvent(2, '1);
      end
   end

   // Expected events of a layer starting at t0: nclr PE_resets, nfin PE_finishes,
   // optional stall of stall_n cycles on pixel stall_k, optional done.
   task automatic pushLayer(input int st, input int acc, input int nclr, input int nfin,
                            input int stall_k, input int stall_n, input bit with_done);
      int base;
      int fin;
      base = st + 4;
      for (int k = 0; k < nclr; k++) begin
         exp_q.push_back('{0, base, k});
         if (k < nfin) begin
            fin = base + acc + 1 + ((k == stall_k) ? stall_n : 0);
            exp_q.push_back('{1, fin, k});
            base = fin + 1;
         end
      end
      if (with_done) exp_q.push_back('{2, base, 0});
   endtask

   task automatic waitCycle(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulses start for one cycle with the given configuration, returns the sample cycle.
   task automatic applyStimulus(input int acc, input int num, output int st);
      cfg_acc_cycles = CNT_W'(acc);
      cfg_num_pixels = CNT_W'(num);
      start = 1'b1;
      st = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      cfg_acc_cycles = 16'h0055;
      cfg_num_pixels = 16'h00aa;
   endtask

   task automatic drainQueue(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("queue_drained", exp_q.size(), 0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ofm_ready = 1'b1;
      cfg_acc_cycles = '0;
      cfg_num_pixels = '0;
      #12;
      checkOutput("rst_cal_start", cal_start, 0);
      checkOutput("rst_pe_reset", PE_reset, 0);
      checkOutput("rst_pe_finish", PE_finish, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_pixel_idx", pixel_idx, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      waitCycle(cyc + 2);

      $display("[TB] layer acc=34 num=4");
      checkOutput("t1_idle_cal_start", cal_start, 0);
      applyStimulus(34, 4, t0);
      pushLayer(t0, 34, 4, 4, -1, 0, 1'b1);
      checkOutput("t1_cal_start_rise", cal_start, 1);
      checkOutput("t1_busy", busy, 1);
      waitCycle(t0 + 148);
      checkOutput("t1_done_busy", busy, 1);
      waitCycle(t0 + 149);
      checkOutput("t1_busy_after", busy, 0);
      checkOutput("t1_cal_after", cal_start, 0);
      drainQueue(20);

      $display("[TB] layer acc=0 num=3");
      applyStimulus(0, 3, t0);
      pushLayer(t0, 0, 3, 3, -1, 0, 1'b1);
      drainQueue(50);

      $display("[TB] backpressure stall");
      applyStimulus(34, 2, t0);
      pushLayer(t0, 34, 2, 2, 0, 10, 1'b1);
      waitCycle(t0 + 38);
      ofm_ready = 1'b0;
      waitCycle(t0 + 44);
      checkOutput("t3_stall_cal_start", cal_start, 1);
      checkOutput("t3_stall_finish", PE_finish, 0);
      waitCycle(t0 + 49);
      ofm_ready = 1'b1;
      drainQueue(100);

      $display("[TB] abort during pixel 5");
      applyStimulus(34, 3136, t0);
      pushLayer(t0, 34, 6, 5, -1, 0, 1'b0);
      waitCycle(t0 + 200);
      checkOutput("t4_pixel_before", pixel_idx, 5);
      abort = 1'b1;
      waitCycle(t0 + 201);
      abort = 1'b0;
      checkOutput("t4_cal_start", cal_start, 0);
      checkOutput("t4_busy", busy, 0);
      checkOutput("t4_pixel_idx", pixel_idx, 0);
      checkOutput("t4_done", done, 0);
      waitCycle(t0 + 210);
      checkOutput("t4_queue", exp_q.size(), 0);
      applyStimulus(2, 2, t0);
      pushLayer(t0, 2, 2, 2, -1, 0, 1'b1);
      checkOutput("t4_restart_pixel", pixel_idx, 0);
      drainQueue(40);

      $display("[TB] empty layer");
      applyStimulus(5, 0, t0);
      exp_q.push_back('{2, t0 + 1, 0});
      checkOutput("t5_cal_start", cal_start, 0);
      checkOutput("t5_busy", busy, 1);
      waitCycle(t0 + 2);
      checkOutput("t5_cal_start2", cal_start, 0);
      checkOutput("t5_busy2", busy, 0);
      drainQueue(5);

      $display("[TB] start with abort in idle");
      abort = 1'b1;
      applyStimulus(3, 2, t0);
      abort = 1'b0;
      checkOutput("t6_busy", busy, 0);
      waitCycle(t0 + 10);
      checkOutput("t6_cal_start", cal_start, 0);

      $display("[TB] reset during pixel 2");
      applyStimulus(34, 4, t0);
      pushLayer(t0, 34, 3, 2, -1, 0, 1'b0);
      waitCycle(t0 + 86);
      checkOutput("t7_pixel_before", pixel_idx, 2);
      reset = 1'b0;
      #1;
      checkOutput("t7_cal_start", cal_start, 0);
      checkOutput("t7_busy", busy, 0);
      checkOutput("t7_pixel_idx", pixel_idx, 0);
      waitCycle(t0 + 88);
      reset = 1'b1;
      waitCycle(t0 + 95);
      checkOutput("t7_idle_busy", busy, 0);
      checkOutput("t7_queue", exp_q.size(), 0);

      $display("[TB] start while busy");
      applyStimulus(5, 3, t0);
      pushLayer(t0, 5, 3, 3, -1, 0, 1'b1);
      waitCycle(t0 + 8);
      cfg_num_pixels = 16'd9;
      start = 1'b1;
      waitCycle(t0 + 9);
      start = 1'b0;
      drainQueue(60);
      waitCycle(cyc + 10);
      checkOutput("t8_busy_end", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
